// File: rtl/vx_mem_req_arbiter.sv
// vx_mem_req_arbiter: 2:1 round-robin arbiter sharing one Vortex memory port
// between requester 0 (core) and requester 1 (host/loader DMA).
// Ports:
//   clk, reset                     clock (rising edge), asynchronous active-high reset
//   in_req_valid/rw/byteen/addr/data/tag [i]  per-requester request inputs
//   in_req_ready[i]                request accepted when valid & ready
//   in_rsp_valid/data/tag[i]       per-requester response outputs (ID bit stripped)
//   in_rsp_ready[i]                requester accepts response
//   mem_req_*                      registered request to memory, tag = {id, in tag}
//   mem_req_ready                  memory accepts request
//   mem_rsp_valid/data/tag         response from memory
//   mem_rsp_ready                  routed from the addressed requester
//   busy                           outstanding reads or buffered request
module vx_mem_req_arbiter #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 26,
    parameter int IN_TAG_WIDTH    = 8,
    parameter int MAX_OUTSTANDING = 16,
    localparam int BE_W      = DATA_WIDTH / 8,
    localparam int OUT_TAG_W = IN_TAG_WIDTH + 1,
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              in_req_valid,
    input  logic [1:0]              in_req_rw,
    input  logic [BE_W-1:0]         in_req_byteen [2],
    input  logic [ADDR_WIDTH-1:0]   in_req_addr [2],
    input  logic [DATA_WIDTH-1:0]   in_req_data [2],
    input  logic [IN_TAG_WIDTH-1:0] in_req_tag [2],
    output logic [1:0]              in_req_ready,
    output logic [1:0]              in_rsp_valid,
    output logic [DATA_WIDTH-1:0]   in_rsp_data [2],
    output logic [IN_TAG_WIDTH-1:0] in_rsp_tag [2],
    input  logic [1:0]              in_rsp_ready,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [BE_W-1:0]         mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [OUT_TAG_W-1:0]    mem_req_tag,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [OUT_TAG_W-1:0]    mem_rsp_tag,
    output logic                    mem_rsp_ready,
    output logic                    busy
);
    logic                  r_valid;
    logic                  r_rw;
    logic                  r_rr;
    logic [BE_W-1:0]       r_byteen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [OUT_TAG_W-1:0]  r_tag;
    logic [CNT_W-1:0]      r_cnt [2];
    logic [1:0]            w_ok;
    logic [1:0]            w_elig;
    logic [1:0]            w_acc;
    logic [1:0]            w_inc;
    logic [1:0]            w_dec;
    logic                  w_slot_free;
    logic                  w_sel;
    logic                  w_rsp_id;
    logic                  w_rsp_hs;

    // Ready for one requester looks only at its own rw/counter and the other
    // requester's eligibility, never at its own valid. The two terms
    // (~elig[other] | pointer) are mutually exclusive when both are eligible,
    // so at most one handshake can occur per cycle.
    always_comb begin
        w_slot_free = ~r_valid | mem_req_ready;
        for (int k = 0; k < 2; k++) begin
            w_ok[k]        = in_req_rw[k] | (r_cnt[k] < CNT_W'(MAX_OUTSTANDING));
            in_rsp_data[k] = mem_rsp_data;
            in_rsp_tag[k]  = mem_rsp_tag[IN_TAG_WIDTH-1:0];
        end
        w_elig          = in_req_valid & w_ok;
        in_req_ready[0] = ~reset & w_slot_free & w_ok[0] & (~w_elig[1] | ~r_rr);
        in_req_ready[1] = ~reset & w_slot_free & w_ok[1] & (~w_elig[0] | r_rr);
        w_acc           = in_req_valid & in_req_ready;
        w_sel           = w_acc[1];
        w_inc           = w_acc & ~in_req_rw;
        w_rsp_id        = mem_rsp_tag[OUT_TAG_W-1];
        mem_rsp_ready   = in_rsp_ready[w_rsp_id];
        w_rsp_hs        = mem_rsp_valid & mem_rsp_ready;
        w_dec           = {w_rsp_hs & w_rsp_id, w_rsp_hs & ~w_rsp_id};
        in_rsp_valid    = (~reset & mem_rsp_valid) ? {w_rsp_id, ~w_rsp_id} : 2'b00;
        busy            = r_valid | (|r_cnt[0]) | (|r_cnt[1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_rw     <= 1'b0;
            r_rr     <= 1'b0;
            r_byteen <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_tag    <= '0;
        end else if (|w_acc) begin
            r_valid  <= 1'b1;
            r_rw     <= in_req_rw[w_sel];
            r_rr     <= ~w_sel;
            r_byteen <= in_req_byteen[w_sel];
            r_addr   <= in_req_addr[w_sel];
            r_data   <= in_req_data[w_sel];
            r_tag    <= {w_sel, in_req_tag[w_sel]};
        end else if (w_slot_free) begin
            r_valid  <= 1'b0;
        end
    end

    // A decrement at zero (stray response) saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_inc[k] & ~w_dec[k])
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                else if (w_dec[k] & ~w_inc[k] & (r_cnt[k] != '0))
                    r_cnt[k] <= r_cnt[k] - 1'b1;
            end
        end
    end

    assign mem_req_valid  = r_valid;
    assign mem_req_rw     = r_rw;
    assign mem_req_byteen = r_byteen;
    assign mem_req_addr   = r_addr;
    assign mem_req_data   = r_data;
    assign mem_req_tag    = r_tag;

    for (genvar i = 0; i < 2; i++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            !(w_dec[i] && r_cnt[i] == '0));
        a_no_overflow: assert property (@(posedge clk) disable iff (reset)
            !(w_inc[i] && r_cnt[i] >= CNT_W'(MAX_OUTSTANDING)));
    end
endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// tb_vx_mem_req_arbiter: directed table-driven bench for vx_mem_req_arbiter
module tb_vx_mem_req_arbiter;
    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    in_req_valid, in_req_rw, in_req_ready, in_rsp_valid, in_rsp_ready;
    logic [BW-1:0] in_req_byteen [2];
    logic [AW-1:0] in_req_addr [2];
    logic [DW-1:0] in_req_data [2];
    logic [TW-1:0] in_req_tag [2];
    logic [DW-1:0] in_rsp_data [2];
    logic [TW-1:0] in_rsp_tag [2];
    logic          mem_req_valid, mem_req_rw, mem_req_ready;
    logic [BW-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW:0]   mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready, busy;
    logic [DW-1:0] mem_rsp_data;
    logic [TW:0]   mem_rsp_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_mem_req_arbiter dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready), .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
        .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy)
    );

    typedef struct {
        logic [1:0] v;
        logic       mrdy;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] rdy;
        logic       mv;
        logic [8:0] mtag;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    logic [DW-1:0] d0, d1, d2, d3;

    initial begin
        tbl[0] = '{2'b11, 1'b1, 8'h10, 8'h20, 2'b01, 1'b1, 9'h010};
        tbl[1] = '{2'b11, 1'b1, 8'h11, 8'h21, 2'b10, 1'b1, 9'h121};
        tbl[2] = '{2'b11, 1'b1, 8'h12, 8'h22, 2'b01, 1'b1, 9'h012};
        tbl[3] = '{2'b11, 1'b1, 8'h13, 8'h23, 2'b10, 1'b1, 9'h123};
        tbl[4] = '{2'b10, 1'b1, 8'h14, 8'h24, 2'b11, 1'b1, 9'h124};
        tbl[5] = '{2'b01, 1'b1, 8'h15, 8'h25, 2'b01, 1'b1, 9'h015};
        tbl[6] = '{2'b00, 1'b1, 8'h16, 8'h26, 2'b11, 1'b0, 9'h000};
        tbl[7] = '{2'b10, 1'b0, 8'h17, 8'h27, 2'b10, 1'b1, 9'h127};
        tbl[8] = '{2'b11, 1'b0, 8'h18, 8'h28, 2'b00, 1'b1, 9'h127};
        tbl[9] = '{2'b11, 1'b1, 8'h19, 8'h29, 2'b01, 1'b1, 9'h019};
        d0 = {16{$urandom}};
        d1 = {16{$urandom}};
        d2 = {16{$urandom}};
        d3 = {16{$urandom}};

        reset = 1'b1;
        in_req_valid = 2'b11;
        in_req_rw = 2'b00;
        in_rsp_ready = 2'b00;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag = '0;
        mem_rsp_data = '0;
        for (int k = 0; k < 2; k++) begin
            in_req_byteen[k] = '1;
            in_req_addr[k] = '0;
            in_req_data[k] = '0;
            in_req_tag[k] = '0;
        end

        repeat (13) begin
            tick();
            chk("rst_ready", in_req_ready, 2'b00);
            chk("rst_mvalid", mem_req_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        in_req_valid = 2'b00;
        reset = 1'b0;

        in_req_rw = 2'b11;
        for (int k = 0; k < 10; k++) begin
            in_req_valid = tbl[k].v;
            in_req_tag[0] = tbl[k].t0;
            in_req_tag[1] = tbl[k].t1;
            mem_req_ready = tbl[k].mrdy;
            settle();
            chk($sformatf("tbl%0d_ready", k), in_req_ready, tbl[k].rdy);
            tick();
            chk($sformatf("tbl%0d_mvalid", k), mem_req_valid, tbl[k].mv);
            if (tbl[k].mv) chk($sformatf("tbl%0d_mtag", k), mem_req_tag, tbl[k].mtag);
        end

        do_reset();
        mem_req_ready = 1'b1;
        in_req_valid = 2'b01;
        in_req_rw = 2'b00;
        in_req_addr[0] = 26'h100;
        in_req_tag[0] = 8'h05;
        in_req_data[0] = d0;
        settle();
        chk("rd0_ready", in_req_ready[0], 1'b1);
        tick();
        in_req_valid = 2'b00;
        chk("rd0_mvalid", mem_req_valid, 1'b1);
        chk("rd0_mtag", mem_req_tag, 9'h005);
        chk("rd0_maddr", mem_req_addr, 26'h100);
        chk("rd0_mrw", mem_req_rw, 1'b0);
        chk("rd0_cnt", dut.r_cnt[0], 1);
        chk("rd0_busy", busy, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag = 9'h005;
        mem_rsp_data = d1;
        in_rsp_ready = 2'b01;
        settle();
        chk("rsp0_valid", in_rsp_valid, 2'b01);
        chk("rsp0_tag", in_rsp_tag[0], 8'h05);
        chk("rsp0_data", in_rsp_data[0], d1);
        chk("rsp0_mready", mem_rsp_ready, 1'b1);
        tick();
        mem_rsp_valid = 1'b0;
        chk("rsp0_cnt", dut.r_cnt[0], 0);
        chk("rsp0_mvalid", mem_req_valid, 1'b0);
        chk("rsp0_busy", busy, 1'b0);

        do_reset();
        mem_req_ready = 1'b0;
        in_req_valid = 2'b10;
        in_req_rw = 2'b11;
        in_req_addr[1] = 26'h200;
        in_req_tag[1] = 8'h33;
        in_req_data[1] = d2;
        settle();
        chk("stall_ready1", in_req_ready[1], 1'b1);
        tick();
        in_req_valid = 2'b11;
        in_req_addr[1] = 26'h204;
        in_req_tag[1] = 8'h34;
        in_req_data[1] = d3;
        in_req_addr[0] = 26'h300;
        in_req_tag[0] = 8'h44;
        repeat (5) begin
            settle();
            chk("stall_ready", in_req_ready, 2'b00);
            chk("stall_mvalid", mem_req_valid, 1'b1);
            chk("stall_mtag", mem_req_tag, 9'h133);
            chk("stall_maddr", mem_req_addr, 26'h200);
            chk("stall_mdata", mem_req_data, d2);
            tick();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("rel_ready_a", in_req_ready, 2'b01);
        tick();
        chk("rel_mtag_a", mem_req_tag, 9'h044);
        chk("rel_maddr_a", mem_req_addr, 26'h300);
        settle();
        chk("rel_ready_b", in_req_ready, 2'b10);
        tick();
        chk("rel_mtag_b", mem_req_tag, 9'h134);
        chk("rel_mdata_b", mem_req_data, d3);
        in_req_valid = 2'b00;
        tick();
        chk("rel_idle", mem_req_valid, 1'b0);

        do_reset();
        mem_req_ready = 1'b1;
        in_req_valid = 2'b01;
        in_req_rw = 2'b00;
        for (int k = 0; k < 16; k++) begin
            in_req_tag[0] = 8'(k);
            settle();
            chk($sformatf("thr_rd%0d_ready", k), in_req_ready[0], 1'b1);
            tick();
        end
        chk("thr_cnt16", dut.r_cnt[0], 16);
        settle();
        chk("thr_rd17_ready", in_req_ready[0], 1'b0);
        in_req_rw = 2'b01;
        settle();
        chk("thr_wr_ready", in_req_ready[0], 1'b1);
        tick();
        chk("thr_wr_mrw", mem_req_rw, 1'b1);
        chk("thr_wr_cnt", dut.r_cnt[0], 16);
        in_req_rw = 2'b10;
        in_req_valid = 2'b11;
        in_req_tag[1] = 8'h55;
        settle();
        chk("thr_req1_ready", in_req_ready, 2'b10);
        tick();
        chk("thr_req1_mtag", mem_req_tag, 9'h155);
        in_req_valid = 2'b01;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag = 9'h003;
        in_rsp_ready = 2'b01;
        settle();
        chk("thr_rsp_ready", in_req_ready[0], 1'b0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("thr_cnt15", dut.r_cnt[0], 15);
        settle();
        chk("thr_after_ready", in_req_ready[0], 1'b1);
        tick();
        in_req_valid = 2'b00;
        chk("thr_after_cnt", dut.r_cnt[0], 16);
        chk("thr_after_mtag", mem_req_tag, 9'h00f);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mvalid", mem_req_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cnt", dut.r_cnt[0], 0);
        tick();
        reset = 1'b0;

        do_reset();
        in_req_valid = 2'b10;
        in_req_rw = 2'b00;
        in_req_tag[1] = 8'h07;
        settle();
        chk("r1_ready", in_req_ready[1], 1'b1);
        tick();
        in_req_valid = 2'b00;
        chk("r1_cnt", dut.r_cnt[1], 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag = 9'h1ab;
        mem_rsp_data = d3;
        in_rsp_ready = 2'b01;
        settle();
        chk("r1_bp_mready", mem_rsp_ready, 1'b0);
        chk("r1_bp_valid", in_rsp_valid, 2'b10);
        chk("r1_bp_tag", in_rsp_tag[1], 8'hab);
        chk("r1_bp_data", in_rsp_data[1], d3);
        tick();
        chk("r1_bp_cnt", dut.r_cnt[1], 1);
        in_rsp_ready = 2'b11;
        settle();
        chk("r1_hs_mready", mem_rsp_ready, 1'b1);
        tick();
        mem_rsp_valid = 1'b0;
        chk("r1_hs_cnt", dut.r_cnt[1], 0);
        in_req_valid = 2'b01;
        in_req_tag[0] = 8'h21;
        settle();
        tick();
        chk("same_pre_cnt", dut.r_cnt[0], 1);
        in_req_tag[0] = 8'h22;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag = 9'h021;
        in_rsp_ready = 2'b01;
        settle();
        chk("same_ready", in_req_ready[0], 1'b1);
        chk("same_rsp_valid", in_rsp_valid, 2'b01);
        tick();
        in_req_valid = 2'b00;
        mem_rsp_valid = 1'b0;
        chk("same_cnt", dut.r_cnt[0], 1);
        chk("same_mtag", mem_req_tag, 9'h022);
        chk("same_busy", busy, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
